// File: rtl/sw_frame_rx.sv
// sw_frame_rx: samples a slow serial switch line on a prescaled tick and decodes start/4-data/stop frames.
module sw_frame_rx #(
  parameter logic [25:0] MAX = 26'd50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_i,
  output logic [3:0] led_o,
  output logic       valid_o,
  output logic       err_o
);
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  state_t      state, state_nxt;
  logic [1:0]  sync;
  logic [25:0] cnt;
  logic [1:0]  bit_cnt, bit_cnt_nxt;
  logic [3:0]  shift, shift_nxt, led_nxt;
  logic        valid_nxt, err_nxt, tick, sample;
  assign sample = sync[1];
  assign tick   = cnt == MAX;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= '0;
      cnt     <= '0;
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      led_o   <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      sync    <= {sync[0], sw_i};
      cnt     <= tick ? '0 : cnt + 26'd1;
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      led_o   <= led_nxt;
      valid_o <= valid_nxt;
      err_o   <= err_nxt;
    end
  end
  // first data bit shifts all the way down to bit 0 after four ticks
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    led_nxt     = led_o;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    if (tick)
      case (state)
        IDLE: if (sample) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
        DATA: begin
          shift_nxt   = {sample, shift[3:1]};
          bit_cnt_nxt = bit_cnt + 2'd1;
          state_nxt   = bit_cnt == 2'd3 ? STOP : DATA;
        end
        STOP: begin
          state_nxt = IDLE;
          err_nxt   = sample;
          valid_nxt = !sample;
          led_nxt   = sample ? led_o : shift;
        end
        default: state_nxt = IDLE;
      endcase
  end
endmodule

// File: tb/tb_sw_frame_rx.sv
// tb_sw_frame_rx: directed frames against a bit-list model of the receiver, checked every cycle.
module tb_sw_frame_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_i = 1'b0;
  logic [3:0] led_o;
  logic       valid_o, err_o;
  int vectors = 0, miscompares = 0;
  bit chk_on = 1'b0;
  bit m_s1, m_s2, exp_valid, exp_err;
  logic [3:0] exp_led, m_data;
  int m_ncyc, m_pos;
  int nv = 0, ne = 0;
  time vtime [0:31];
  logic [3:0] vled [0:31];
  time rel_t;
  int nv0, ne0;
  sw_frame_rx #(.MAX(26'd3)) dut (
    .clk(clk), .rst(rst), .sw_i(sw_i), .led_o(led_o), .valid_o(valid_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask
  // model: sample = input two edges old, tick on every 4th edge after reset, frame as a bit list
  initial forever begin
    bit smp, tk;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_ncyc = 0; m_pos = 0; m_data = '0;
      exp_led = '0; exp_valid = 0; exp_err = 0;
    end else begin
      tk = (m_ncyc % 4) == 3;
      smp = m_s2; m_s2 = m_s1; m_s1 = sw_i; m_ncyc++;
      exp_valid = 0; exp_err = 0;
      if (tk) begin
        if (m_pos == 0) m_pos = smp ? 1 : 0;
        else if (m_pos <= 4) begin m_data[m_pos-1] = smp; m_pos++; end
        else begin
          if (smp) exp_err = 1;
          else begin exp_led = m_data; exp_valid = 1; end
          m_pos = 0;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("led", {28'd0, led_o}, {28'd0, exp_led});
      check("valid", {31'd0, valid_o}, {31'd0, exp_valid});
      check("err", {31'd0, err_o}, {31'd0, exp_err});
      if (valid_o === 1'b1) begin vtime[nv] = $time; vled[nv] = led_o; nv++; end
      if (err_o === 1'b1) ne++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic send(input bit b);
    sw_i = b;
    repeat (4) @(negedge clk);
  endtask
  task automatic frame(input bit [3:0] d, input bit stop);
    send(1);
    for (int i = 0; i < 4; i++) send(d[i]);
    send(stop);
  endtask
  initial begin
    #7 rst = 1'b0;
    #1;
    check("rst_led", {28'd0, led_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rel_t = $time;
    frame(4'b1101, 0);
    send(0);
    check("good_cnt_valid", nv, 1);
    check("good_cnt_err", ne, 0);
    check("good_led", {28'd0, led_o}, 32'h0000000d);
    check("first_tick_latency", vtime[0] - rel_t, 240);
    frame(4'b0100, 1);
    send(0);
    check("ferr_cnt_err", ne, 1);
    check("ferr_cnt_valid", nv, 1);
    check("ferr_led", {28'd0, led_o}, 32'h0000000d);
    frame(4'b0110, 0);
    frame(4'b1111, 0);
    send(0);
    check("b2b_cnt_valid", nv, 3);
    check("b2b_first_led", {28'd0, vled[1]}, 32'h00000006);
    check("b2b_second_led", {28'd0, vled[2]}, 32'h0000000f);
    check("b2b_spacing", vtime[2] - vtime[1], 240);
    nv0 = nv; ne0 = ne;
    repeat (5) send(0);
    sw_i = 1'b1;
    @(negedge clk);
    sw_i = 1'b0;
    repeat (3) @(negedge clk);
    repeat (14) send(0);
    check("glitch_cnt_valid", nv, nv0);
    check("glitch_cnt_err", ne, ne0);
    check("glitch_led", {28'd0, led_o}, 32'h0000000f);
    send(1); send(0); send(0);
    #2 rst = 1'b0;
    #1;
    check("midrst_led", {28'd0, led_o}, 32'd0);
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rel_t = $time;
    nv0 = nv; ne0 = ne;
    frame(4'b1000, 0);
    send(0); send(0);
    check("midrst_cnt_valid", nv, nv0 + 1);
    check("midrst_cnt_err", ne, ne0);
    check("midrst_final_led", {28'd0, led_o}, 32'h00000008);
    check("midrst_latency", vtime[nv0] - rel_t, 240);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
